// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Two-flop input synchronizer, mid-bit
//               sampling, one-byte holding register with valid/ready
//               handshake, and one-cycle frame-error / overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int c_HALF_BIT     = c_CLKS_PER_BIT / 2;
    localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_idx;
    logic [7:0]           r_shreg;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_cnt_last;
    logic                 w_cnt_clr;
    logic                 w_idx_clr;
    logic                 w_shift;
    logic                 w_stop_ok;
    logic                 w_stop_bad;
    logic                 w_can_load;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    // The holding register can take a new byte if it is empty or is being
    // drained on this very edge.
    assign w_can_load = ~r_rx_valid | rx_ready;

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_idx_clr    = 1'b0;
        w_shift      = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_clr = 1'b1;
                    if (!r_rx_s) begin
                        w_state_next = S_DATA;
                        w_idx_clr    = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_shift = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    if (r_rx_s) begin
                        w_stop_ok    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it is not taken as a new start.
                w_cnt_clr = 1'b1;
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Baud counter: free-runs 0..CLKS_PER_BIT-1, cleared on FSM request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr || w_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 3'd0;
            r_shreg <= 8'h00;
        end else if (w_idx_clr) begin
            r_idx <= 3'd0;
        end else if (w_shift) begin
            r_shreg[r_idx] <= r_rx_s;
            r_idx          <= r_idx + 3'd1;
        end
    end

    // Holding register, handshake and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_stop_ok & ~w_can_load;
            if (w_stop_ok && w_can_load) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (16 clocks per bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLKS = 16;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int vectors = 0;
    int errors  = 0;

    int cyc       = 0;
    int start_cyc = 0;
    int rise_cyc  = -1;
    int n_valid_hi = 0;
    int n_ferr     = 0;
    int n_ovr      = 0;
    int n_both     = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ(1_600_000),
        .BAUD    (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the DUT mid-cycle: log transfers and count pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_valid) n_valid_hi++;
            if (rx_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (frame_err && overrun) n_both++;
            prev_valid = rx_valid;
        end
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        got.delete();
        exp_q.delete();
        n_valid_hi = 0;
        n_ferr     = 0;
        n_ovr      = 0;
        rise_cyc   = -1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(CLKS);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        tick(CLKS);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        tick(3);
        vectors++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
        vectors++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
        rst = 1'b0;
        tick(4);
        vectors++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", rx_valid); end
    endtask

    task automatic test_basic();
        int lat;
        rx_ready = 1'b1;
        clear_obs();
        send_byte(8'hA5, 1'b1);
        tick(8);
        lat = rise_cyc - start_cyc;
        vectors++;
        if (got.size() != 1) begin errors++; $display("FAIL basic_count got %0d want 1", got.size()); end
        else if (got[0] !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", got[0]); end
        vectors++; if (n_valid_hi != 1) begin errors++; $display("FAIL basic_valid_width got %0d want 1", n_valid_hi); end
        vectors++; if (n_ferr != 0 || n_ovr != 0) begin errors++; $display("FAIL basic_flags got ferr=%0d ovr=%0d want 0/0", n_ferr, n_ovr); end
        vectors++; if (rise_cyc < 0 || lat < 154 || lat > 156) begin errors++; $display("FAIL basic_latency got %0d want 155+/-1", lat); end
    endtask

    task automatic test_glitch();
        clear_obs();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        vectors++; if (n_valid_hi != 0 || n_ferr != 0) begin errors++; $display("FAIL glitch_quiet got valid=%0d ferr=%0d want 0/0", n_valid_hi, n_ferr); end
        send_byte(8'h3C, 1'b1);
        tick(8);
        vectors++;
        if (got.size() != 1) begin errors++; $display("FAIL glitch_count got %0d want 1", got.size()); end
        else if (got[0] !== 8'h3C) begin errors++; $display("FAIL glitch_data got %h want 3c", got[0]); end
    endtask

    task automatic test_frame_err();
        clear_obs();
        send_byte(8'h55, 1'b0);
        tick(40);
        vectors++; if (n_ferr != 1) begin errors++; $display("FAIL ferr_pulse got %0d want 1", n_ferr); end
        vectors++; if (n_valid_hi != 0 || got.size() != 0) begin errors++; $display("FAIL ferr_novalid got %0d want 0", n_valid_hi); end
        rx = 1'b1;
        tick(20);
        send_byte(8'h81, 1'b1);
        tick(8);
        vectors++;
        if (got.size() != 1) begin errors++; $display("FAIL ferr_recover_count got %0d want 1", got.size()); end
        else if (got[0] !== 8'h81) begin errors++; $display("FAIL ferr_recover_data got %h want 81", got[0]); end
        vectors++; if (n_ferr != 1 || n_ovr != 0) begin errors++; $display("FAIL ferr_total got ferr=%0d ovr=%0d want 1/0", n_ferr, n_ovr); end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        clear_obs();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(8);
        vectors++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_hold_data got %h want 11", rx_data); end
        vectors++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold_valid got %b want 1", rx_valid); end
        vectors++; if (n_ovr != 1 || n_ferr != 0) begin errors++; $display("FAIL ovr_pulse got ovr=%0d ferr=%0d want 1/0", n_ovr, n_ferr); end
        rx_ready = 1'b1;
        tick(1);
        vectors++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid got %b want 0", rx_valid); end
        vectors++;
        if (got.size() != 1) begin errors++; $display("FAIL ovr_drain_count got %0d want 1", got.size()); end
        else if (got[0] !== 8'h11) begin errors++; $display("FAIL ovr_drain_data got %h want 11", got[0]); end
        vectors++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_stable got %h want 11", rx_data); end
    endtask

    task automatic test_back_to_back();
        rx_ready = 1'b1;
        clear_obs();
        exp_q = '{8'h00, 8'hFF, 8'h5A};
        foreach (exp_q[i]) send_byte(exp_q[i], 1'b1);
        tick(8);
        vectors++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", got.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
        vectors++; if (n_ferr != 0 || n_ovr != 0) begin errors++; $display("FAIL b2b_flags got ferr=%0d ovr=%0d want 0/0", n_ferr, n_ovr); end
        vectors++; if (n_valid_hi != 3) begin errors++; $display("FAIL b2b_valid_cycles got %0d want 3", n_valid_hi); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int gap;
        rx_ready = 1'b1;
        clear_obs();
        for (int k = 0; k < 10; k++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 12);
            exp_q.push_back(b);
            send_byte(b, 1'b1);
            tick(gap);
        end
        tick(8);
        vectors++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_data[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
        vectors++; if (n_ferr != 0 || n_ovr != 0) begin errors++; $display("FAIL rand_flags got ferr=%0d ovr=%0d want 0/0", n_ferr, n_ovr); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'hC3;
        clear_obs();
        rx = 1'b0;
        tick(CLKS);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        tick(CLKS / 2);
        rst = 1'b1;
        tick(2);
        vectors++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_outputs got data=%h valid=%b want 00/0", rx_data, rx_valid); end
        vectors++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_flags got ferr=%b ovr=%b want 0/0", frame_err, overrun); end
        rx = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(CLKS * 12);
        vectors++; if (got.size() != 0 || n_ferr != 0 || rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_abandon got bytes=%0d ferr=%0d want 0/0", got.size(), n_ferr); end
        send_byte(8'h7E, 1'b1);
        tick(8);
        vectors++;
        if (got.size() != 1) begin errors++; $display("FAIL midrst_next_count got %0d want 1", got.size()); end
        else if (got[0] !== 8'h7E) begin errors++; $display("FAIL midrst_next_data got %h want 7e", got[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        vectors++; if (n_both != 0) begin errors++; $display("FAIL flag_exclusive got %0d want 0", n_both); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
